// File: rtl/cpu_ctrl_fsm_if.sv
// Bus between the control sequencer and the memory / PC / ALU datapath.
// The controller side uses the master modport. The datapath and memory side uses slave.
interface cpu_ctrl_fsm_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              zero_flag;
  logic              load_pc;
  logic              inc_pc;
  logic [ADDR_W-1:0] jump_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              addr_sel;
  logic [7:0]        ir;
  logic [1:0]        alu_op;
  logic              acc_load;
  logic              halted;
  logic              fault;

  modport master (
    input  start, mem_rdata, mem_ready, zero_flag,
    output load_pc, inc_pc, jump_addr, mem_rd, mem_wr, addr_sel,
           ir, alu_op, acc_load, halted, fault
  );

  modport slave (
    output start, mem_rdata, mem_ready, zero_flag,
    input  load_pc, inc_pc, jump_addr, mem_rd, mem_wr, addr_sel,
           ir, alu_op, acc_load, halted, fault
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
// It drives the PC controls and the memory strobes, and it holds the instruction register.
// It also issues the accumulator/ALU commands.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ADDR_W      = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_JUMP, S_SETTLE, S_HALT
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       fault_q, fault_d;
  logic [7:0] tmo_q, tmo_d;

  logic [2:0] opcode;
  logic       acc_op;
  logic [7:0] tmo_inc;

  logic       load_pc, inc_pc, mem_rd, mem_wr, addr_sel, acc_load, halted;
  logic [1:0] alu_op;

  assign opcode  = ir_q[7:5];
  assign acc_op  = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
  assign tmo_inc = tmo_q + 8'd1;

  // State register, instruction register, sticky fault and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      fault_q <= 1'b0;
      tmo_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: sequencing, IR capture, timeout detection and fault update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fault_d = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          state_d = S_DECODE;
        end else if (tmo_inc == TMO_LIMIT) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:                         state_d = S_SETTLE;
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = S_EXEC;
          OP_JMP:                         state_d = S_JUMP;
          OP_JZ:                          state_d = bus.zero_flag ? S_JUMP : S_SETTLE;
          OP_HLT:                         state_d = S_HALT;
          default:                        state_d = S_SETTLE;
        endcase
      end
      S_EXEC: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_inc == TMO_LIMIT) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_JUMP: state_d = S_SETTLE;
      S_HALT: begin
        if (bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear the counter on any state change so that each FETCH or EXEC entry starts from zero.
    if (state_d != state_q) tmo_d = 8'h00;
  end

  // Output decode: state-based controls, plus acc_load gated by mem_ready and mem_wr gated by the opcode
  always_comb begin
    load_pc  = 1'b1;
    inc_pc   = 1'b1;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    alu_op   = 2'b00;
    acc_load = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_pc = 1'b0;
        inc_pc  = 1'b0;
      end
      S_FETCH: mem_rd = 1'b1;
      S_DECODE: load_pc = 1'b0;
      S_EXEC: begin
        addr_sel = 1'b1;
        mem_rd   = acc_op;
        mem_wr   = (opcode == OP_STA);
        acc_load = acc_op && bus.mem_ready;
        if (opcode == OP_ADD)      alu_op = 2'b01;
        else if (opcode == OP_SUB) alu_op = 2'b10;
        else                       alu_op = 2'b00;
      end
      S_JUMP: inc_pc = 1'b0;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_pc   = load_pc;
  assign bus.inc_pc    = inc_pc;
  assign bus.jump_addr = ADDR_W'(ir_q[4:0]);
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.addr_sel  = addr_sel;
  assign bus.ir        = ir_q;
  assign bus.alu_op    = alu_op;
  assign bus.acc_load  = acc_load;
  assign bus.halted    = halted;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm.
// Each stimulus cycle pushes its expected output vector onto a scoreboard.
// A monitor process pops that vector and compares it mid-cycle.
module tb_cpu_ctrl_fsm;

  localparam int TI = 0, TS = 1, TF = 2, TD = 3, TE = 4, TJ = 5, TH = 6;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [7:0] cur_ir;
  logic       exp_fault;

  cpu_ctrl_fsm_if #(.ADDR_W(5)) bus ();

  cpu_ctrl_fsm #(.MEM_TIMEOUT(15), .ADDR_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [22:0] obs;
  assign obs = {bus.ir, bus.jump_addr, bus.load_pc, bus.inc_pc, bus.mem_rd, bus.mem_wr,
                bus.addr_sel, bus.alu_op, bus.acc_load, bus.halted, bus.fault};

  // Free-running clock: posedge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for a given controller state, IR contents, mem_ready and fault value
  function automatic logic [22:0] exp_out(input int s, input logic [7:0] irv, input logic rdy,
                                          input logic flt);
    logic [2:0] op;
    logic       memop, rd, wr, as, al, h;
    logic [1:0] pc, alu;
    op    = irv[7:5];
    memop = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
    pc = 2'b11; rd = 1'b0; wr = 1'b0; as = 1'b0; al = 1'b0; h = 1'b0; alu = 2'b00;
    case (s)
      TI: pc = 2'b00;
      TD: pc = 2'b01;
      TJ: pc = 2'b10;
      TF: rd = 1'b1;
      TH: h = 1'b1;
      TE: begin
        as = 1'b1;
        rd = memop;
        wr = (op == 3'd2);
        al = memop & rdy;
        if (op == 3'd3)      alu = 2'b01;
        else if (op == 3'd4) alu = 2'b10;
      end
      default: ;
    endcase
    return {irv, irv[4:0], pc, rd, wr, as, alu, al, h, flt};
  endfunction

  task automatic checkOutput(input string tag, input logic [22:0] observed, input logic [22:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected outputs for that cycle.
  task automatic applyStimulus(input logic st, input logic [7:0] rd, input logic rdy, input logic zf,
                               input int s, input string tag);
    exp_t e;
    @(negedge clk);
    bus.start     = st;
    bus.mem_rdata = rd;
    bus.mem_ready = rdy;
    bus.zero_flag = zf;
    e.tag = tag;
    e.v   = exp_out(s, cur_ir, rdy, exp_fault);
    sb.push_back(e);
    if (s == TF && rdy) cur_ir = rd;
  endtask

  // Monitor: compare queued expectations 2 time units after each falling edge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, obs, e.v);
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    cur_ir    = 8'h00;
    exp_fault = 1'b0;
    bus.start = 1'b0; bus.mem_rdata = 8'h00; bus.mem_ready = 1'b0; bus.zero_flag = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 checkOutput("reset", obs, exp_out(TI, 8'h00, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;

    // Start, then LDA 0x0A with single-cycle memory
    applyStimulus(1, 8'h00, 0, 0, TI, "idle_start");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle0");
    applyStimulus(0, 8'h2A, 1, 0, TF, "fetch_lda");
    applyStimulus(0, 8'h00, 1, 0, TD, "decode_lda");
    applyStimulus(0, 8'h00, 1, 0, TE, "exec_lda");
    // STA 0x07 with a 3-cycle memory
    applyStimulus(0, 8'h47, 1, 0, TF, "fetch_sta");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_sta");
    applyStimulus(0, 8'h00, 0, 0, TE, "exec_sta_w1");
    applyStimulus(0, 8'h00, 0, 0, TE, "exec_sta_w2");
    applyStimulus(0, 8'h00, 1, 0, TE, "exec_sta_w3");
    // ADD 0x01
    applyStimulus(0, 8'h61, 1, 0, TF, "fetch_add");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_add");
    applyStimulus(0, 8'h00, 1, 0, TE, "exec_add");
    // SUB 0x02 after one wait cycle in which start is driven and must be ignored
    applyStimulus(1, 8'h00, 0, 0, TF, "fetch_wait_start");
    applyStimulus(0, 8'h82, 1, 0, TF, "fetch_sub");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_sub");
    applyStimulus(0, 8'h00, 1, 0, TE, "exec_sub");
    // NOP
    applyStimulus(0, 8'h00, 1, 0, TF, "fetch_nop");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_nop");
    applyStimulus(0, 8'h00, 1, 0, TS, "settle_nop");
    // JZ taken
    applyStimulus(0, 8'hD3, 1, 0, TF, "fetch_jz1");
    applyStimulus(0, 8'h00, 0, 1, TD, "decode_jz1");
    applyStimulus(0, 8'h00, 0, 0, TJ, "jump_jz1");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_jz1");
    // JZ not taken
    applyStimulus(0, 8'hD3, 1, 0, TF, "fetch_jz0");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_jz0");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_jz0");
    // JMP 0x04
    applyStimulus(0, 8'hA4, 1, 0, TF, "fetch_jmp");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_jmp");
    applyStimulus(0, 8'h00, 0, 0, TJ, "jump_jmp");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_jmp");
    // HLT, hold with mem_ready ignored, then restart
    applyStimulus(0, 8'hE0, 1, 0, TF, "fetch_hlt");
    applyStimulus(0, 8'h00, 0, 0, TD, "decode_hlt");
    applyStimulus(0, 8'h00, 0, 0, TH, "halt1");
    applyStimulus(0, 8'h00, 1, 0, TH, "halt2_ready");
    applyStimulus(0, 8'h00, 0, 0, TH, "halt3");
    applyStimulus(1, 8'h00, 0, 0, TH, "halt_start");
    applyStimulus(0, 8'h00, 0, 0, TI, "idle_after_halt");
    applyStimulus(1, 8'h00, 0, 0, TI, "idle_restart");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_restart");
    // Fetch timeout: 15 cycles without mem_ready
    for (int i = 0; i < 15; i++) applyStimulus(0, 8'hFF, 0, 0, TF, $sformatf("fetch_tmo%0d", i));
    exp_fault = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, TH, "halt_fault1");
    applyStimulus(0, 8'h00, 1, 0, TH, "halt_fault2");
    applyStimulus(1, 8'h00, 0, 0, TH, "halt_fault_start");
    applyStimulus(0, 8'h00, 0, 0, TI, "idle_fault_held");
    applyStimulus(1, 8'h00, 0, 0, TI, "idle_fault_start");
    exp_fault = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_fault_clr");

    // Asynchronous reset in the middle of a FETCH cycle
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 checkOutput("pre_rst_fetch", obs, exp_out(TF, cur_ir, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1 checkOutput("rst_mid_fetch", obs, exp_out(TI, 8'h00, 1'b0, 1'b0));
    cur_ir = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(1, 8'h00, 0, 0, TI, "idle_after_rst");
    applyStimulus(0, 8'h00, 0, 0, TS, "settle_after_rst");
    applyStimulus(0, 8'h2A, 0, 0, TF, "fetch_after_rst");

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
